// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locked arbiter sharing one UART transmit handshake
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int LOCK_TIMEOUT = 16,
    parameter int START_GUARD  = 3
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [N_REQ-1:0]     Req_Valid,
    input  logic [8*N_REQ-1:0]   Req_Data,
    input  logic [N_REQ-1:0]     Req_Last,
    output logic [N_REQ-1:0]     Req_Ready,
    output logic [N_REQ-1:0]     Grant,
    output logic                 TX_Valid,
    output logic [7:0]           TX_DataIn,
    input  logic                 TX_Ready,
    output logic                 Busy,
    output logic [N_REQ-1:0]     Timeout_Err
);

    localparam int IW = $clog2(N_REQ);
    localparam int LW = (LOCK_TIMEOUT < 2) ? 1 : $clog2(LOCK_TIMEOUT);
    localparam int GW = (START_GUARD < 1) ? 1 : $clog2(START_GUARD + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic               valid_q, valid_d;
    logic [7:0]         data_q, data_d;
    logic               last_q, last_d;
    logic [LW-1:0]      lock_q, lock_d;
    logic [GW-1:0]      guard_q, guard_d;
    logic [N_REQ-1:0]   err_q, err_d;

    logic               hit;
    logic [IW-1:0]      hit_idx;
    logic [IW:0]        cand_sum;
    logic [IW-1:0]      cand;
    logic [GW-1:0]      guard_inc;

    // Successor of the owner, wrapping the last requester back to 0
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(N_REQ - 1)) ? '0 : i + IW'(1);
    endfunction

    // Round-robin search: first valid requester at or after the pointer
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        cand_sum = '0;
        cand     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_sum = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand_sum >= (IW+1)'(N_REQ)) begin
                cand_sum = cand_sum - (IW+1)'(N_REQ);
            end
            cand = cand_sum[IW-1:0];
            if (!hit && Req_Valid[cand]) begin
                hit     = 1'b1;
                hit_idx = cand;
            end
        end
    end

    // Next-state logic for the grant/byte sequencing FSM
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        valid_d   = valid_q;
        data_d    = data_q;
        last_d    = last_q;
        lock_d    = lock_q;
        guard_d   = guard_q;
        err_d     = '0;
        guard_inc = guard_q + GW'(1);

        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    grant_d          = '0;
                    grant_d[hit_idx] = 1'b1;
                    owner_d          = hit_idx;
                    lock_d           = '0;
                    state_d          = S_LOAD;
                end
            end
            S_LOAD: begin
                if (Req_Valid[owner_q]) begin
                    data_d  = Req_Data[{owner_q, 3'b000} +: 8];
                    last_d  = Req_Last[owner_q];
                    valid_d = 1'b1;
                    lock_d  = '0;
                    state_d = S_ISSUE;
                end else if (lock_q == LW'(LOCK_TIMEOUT - 1)) begin
                    // Owner stalled mid-packet: revoke and abandon the packet
                    err_d   = grant_q;
                    grant_d = '0;
                    ptr_d   = next_idx(owner_q);
                    lock_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    lock_d = lock_q + LW'(1);
                end
            end
            S_ISSUE: begin
                if (TX_Ready) begin
                    valid_d = 1'b0;
                    guard_d = '0;
                    state_d = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                // Wait for the UART to show busy, but never longer than the guard
                if (!TX_Ready) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    guard_d = guard_inc;
                    if (guard_inc == GW'(START_GUARD)) begin
                        state_d = S_WAIT_DONE;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (TX_Ready) begin
                    if (last_q) begin
                        grant_d = '0;
                        ptr_d   = next_idx(owner_q);
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs, asynchronously cleared
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            last_q  <= 1'b0;
            lock_q  <= '0;
            guard_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            lock_q  <= lock_d;
            guard_q <= guard_d;
            err_q   <= err_d;
        end
    end

    assign Req_Ready   = (state_q == S_LOAD) ? grant_q : '0;
    assign Grant       = grant_q;
    assign TX_Valid    = valid_q;
    assign TX_DataIn   = data_q;
    assign Busy        = (state_q != S_IDLE);
    assign Timeout_Err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           Clk = 1'b0;
    logic           Rst = 1'b0;
    logic [N-1:0]   Req_Valid = '0;
    logic [8*N-1:0] Req_Data = '0;
    logic [N-1:0]   Req_Last = '0;
    logic [N-1:0]   Req_Ready;
    logic [N-1:0]   Grant;
    logic           TX_Valid;
    logic [7:0]     TX_DataIn;
    logic           TX_Ready = 1'b1;
    logic           Busy;
    logic [N-1:0]   Timeout_Err;

    uart_tx_arbiter #(.N_REQ(N), .LOCK_TIMEOUT(16), .START_GUARD(3)) dut (
        .Clk(Clk), .Rst(Rst),
        .Req_Valid(Req_Valid), .Req_Data(Req_Data), .Req_Last(Req_Last),
        .Req_Ready(Req_Ready), .Grant(Grant),
        .TX_Valid(TX_Valid), .TX_DataIn(TX_DataIn), .TX_Ready(TX_Ready),
        .Busy(Busy), .Timeout_Err(Timeout_Err)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_bad = 0;
    int inv_err = 0;

    bit   model_en = 1'b0;
    bit   never_fall = 1'b0;
    bit   pend = 1'b0;
    int   frame_len = 4;
    int   cnt = 0;

    logic [7:0]   mem_d [N][8];
    logic         mem_l [N][8];
    int           head [N];
    int           tail [N];
    logic [N-1:0] take = '0;

    logic [7:0]   rx_d [64];
    logic [N-1:0] rx_g [64];
    int           rx_n = 0;
    int           to_cnt [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            if (head[i] < tail[i]) begin
                Req_Valid[i]        = 1'b1;
                Req_Data[8*i +: 8]  = mem_d[i][head[i]];
                Req_Last[i]         = mem_l[i][head[i]];
            end else begin
                Req_Valid[i] = 1'b0;
            end
        end
    endtask

    task automatic push(input int id, input logic [7:0] d, input logic l);
        mem_d[id][tail[id]] = d;
        mem_l[id][tail[id]] = l;
        tail[id]++;
        drive_reqs();
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        Req_Valid = '0;
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
            to_cnt[i] = 0;
        end
        take = '0;
        rx_n = 0;
        never_fall = 1'b0;
        frame_len = 4;
        repeat (2) @(posedge Clk);
        #2;
        Rst = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int k;
        for (k = 0; k < limit; k++) begin
            if (!Busy && Req_Valid == '0 && TX_Ready) break;
            tick();
        end
        chk({name, " done"}, 32'(k < limit), 32'd1);
    endtask

    // Requester model: pop a byte once the arbiter has taken it
    always @(posedge Clk) begin
        #1;
        if (model_en && !Rst) begin
            for (int i = 0; i < N; i++) begin
                if (take[i] && head[i] < tail[i]) head[i]++;
            end
            drive_reqs();
        end
    end

    always @(negedge Clk) begin
        take = Req_Ready & Req_Valid;
    end

    // UART model: accept when idle, drop TX_Ready for a frame, then rise
    always @(negedge Clk) begin
        if (Rst) begin
            TX_Ready = 1'b1;
            pend = 1'b0;
            cnt = 0;
        end else begin
            if (pend) begin
                pend = 1'b0;
                if (!never_fall) begin
                    TX_Ready = 1'b0;
                    cnt = frame_len;
                end
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) TX_Ready = 1'b1;
            end
            if (TX_Valid && TX_Ready) begin
                if (rx_n < 64) begin
                    rx_d[rx_n] = TX_DataIn;
                    rx_g[rx_n] = Grant;
                end
                rx_n++;
                pend = 1'b1;
            end
        end
    end

    // Structural invariants and timeout pulse counting
    always @(negedge Clk) begin
        if (!Rst) begin
            if (!$onehot0(Grant)) inv_err++;
            if (!$onehot0(Req_Ready)) inv_err++;
            if ((Req_Ready & ~Grant) != '0) inv_err++;
            if (TX_Valid && !Busy) inv_err++;
            for (int i = 0; i < N; i++) to_cnt[i] += int'(Timeout_Err[i]);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [3:0] valid;
        logic [3:0] grant;
        logic [7:0] data;
    } vec_t;

    vec_t vt [7];
    int   t_rise [2];
    int   np;
    int   c;
    int   k;
    int   loadc;
    bit   seen;
    bit   prev_v;
    logic [7:0] exp_d [4];
    logic [3:0] exp_g [4];

    initial begin
        vt[0] = '{4'b0001, 4'b0001, 8'h10};
        vt[1] = '{4'b0100, 4'b0100, 8'h12};
        vt[2] = '{4'b1100, 4'b0100, 8'h12};
        vt[3] = '{4'b1000, 4'b1000, 8'h13};
        vt[4] = '{4'b1111, 4'b0001, 8'h10};
        vt[5] = '{4'b1010, 4'b0010, 8'h11};
        vt[6] = '{4'b0000, 4'b0000, 8'h00};

        // Reset values, before any clock edge
        #1 Rst = 1'b1;
        #1;
        chk("rst grant", 32'(Grant), 0);
        chk("rst tx_valid", 32'(TX_Valid), 0);
        chk("rst tx_data", 32'(TX_DataIn), 0);
        chk("rst timeout", 32'(Timeout_Err), 0);
        chk("rst ready", 32'(Req_Ready), 0);
        chk("rst busy", 32'(Busy), 0);

        // Table: priority search from pointer 0
        Req_Data = 32'h13121110;
        Req_Last = '1;
        for (int v = 0; v < 7; v++) begin
            do_reset();
            Req_Data = 32'h13121110;
            Req_Last = '1;
            Req_Valid = vt[v].valid;
            tick();
            chk($sformatf("vec%0d grant", v), 32'(Grant), 32'(vt[v].grant));
            chk($sformatf("vec%0d ready", v), 32'(Req_Ready), 32'(vt[v].grant));
            chk($sformatf("vec%0d busy", v), 32'(Busy), 32'(vt[v].grant != 0));
            tick();
            chk($sformatf("vec%0d tx_valid", v), 32'(TX_Valid), 32'(vt[v].grant != 0));
            chk($sformatf("vec%0d tx_data", v), 32'(TX_DataIn), 32'(vt[v].data));
        end

        model_en = 1'b1;

        // Single request from requester 2
        do_reset();
        push(2, 8'hA5, 1'b1);
        tick();
        chk("single grant", 32'(Grant), 32'b0100);
        chk("single ready", 32'(Req_Ready), 32'b0100);
        tick();
        chk("single tx_valid", 32'(TX_Valid), 1);
        chk("single tx_data", 32'(TX_DataIn), 32'hA5);
        chk("single ready drop", 32'(Req_Ready), 0);
        tick();
        chk("single tx_valid one cycle", 32'(TX_Valid), 0);
        wait_idle("single", 100);
        chk("single rx_n", 32'(rx_n), 1);
        chk("single rx_d", 32'(rx_d[0]), 32'hA5);
        chk("single rx_g", 32'(rx_g[0]), 32'b0100);
        chk("single grant end", 32'(Grant), 0);
        push(0, 8'hB0, 1'b1);
        push(3, 8'hB3, 1'b1);
        tick();
        chk("ptr3 grant", 32'(Grant), 32'b1000);
        wait_idle("ptr3", 200);
        chk("ptr3 rx_n", 32'(rx_n), 3);
        chk("ptr3 rx_g1", 32'(rx_g[1]), 32'b1000);
        chk("ptr3 rx_g2 wrap", 32'(rx_g[2]), 32'b0001);
        chk("ptr3 rx_d2", 32'(rx_d[2]), 32'hB0);

        // Contention: two rounds of all four requesters
        do_reset();
        for (int i = 0; i < N; i++) push(i, 8'(8'h40 + i), 1'b1);
        wait_idle("cont1", 300);
        for (int i = 0; i < N; i++) push(i, 8'(8'h50 + i), 1'b1);
        wait_idle("cont2", 300);
        chk("cont rx_n", 32'(rx_n), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("cont g%0d", i), 32'(rx_g[i]), 32'(1 << (i % 4)));
            chk($sformatf("cont d%0d", i), 32'(rx_d[i]),
                32'((i < 4) ? (8'h40 + i) : (8'h50 + i - 4)));
        end

        // Packet lock: requester 1 keeps the UART for its whole packet
        do_reset();
        push(1, 8'h11, 1'b0);
        push(1, 8'h22, 1'b0);
        push(1, 8'h33, 1'b1);
        tick();
        chk("lock grant", 32'(Grant), 32'b0010);
        push(0, 8'h55, 1'b1);
        wait_idle("lock", 300);
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h55;
        exp_g[0] = 4'b0010; exp_g[1] = 4'b0010; exp_g[2] = 4'b0010; exp_g[3] = 4'b0001;
        chk("lock rx_n", 32'(rx_n), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("lock d%0d", i), 32'(rx_d[i]), 32'(exp_d[i]));
            chk($sformatf("lock g%0d", i), 32'(rx_g[i]), 32'(exp_g[i]));
        end

        // Stall timeout: requester 3 abandons its packet
        do_reset();
        push(3, 8'h7E, 1'b0);
        seen = 1'b0;
        loadc = 0;
        for (k = 0; k < 100; k++) begin
            tick();
            if (TX_Valid) seen = 1'b1;
            else if (seen && Req_Ready[3]) loadc++;
            if (Timeout_Err != '0) break;
        end
        chk("stall reached", 32'(k < 100), 1);
        chk("stall load cycles", 32'(loadc), 16);
        chk("stall err", 32'(Timeout_Err), 32'b1000);
        chk("stall grant", 32'(Grant), 0);
        chk("stall busy", 32'(Busy), 0);
        tick();
        chk("stall err pulse", 32'(Timeout_Err), 0);
        push(1, 8'hC1, 1'b1);
        push(3, 8'hC3, 1'b1);
        tick();
        chk("stall next grant", 32'(Grant), 32'b0010);
        wait_idle("stall", 200);
        chk("stall err count", 32'(to_cnt[3]), 1);
        chk("stall rx_n", 32'(rx_n), 3);

        // Guard: UART never shows busy, WAIT_START must time out
        do_reset();
        never_fall = 1'b1;
        push(2, 8'hA1, 1'b0);
        push(2, 8'hA2, 1'b1);
        np = 0;
        c = 0;
        prev_v = 1'b0;
        for (k = 0; k < 100 && np < 2; k++) begin
            tick();
            c++;
            if (TX_Valid && !prev_v) begin
                t_rise[np] = c;
                np++;
            end
            prev_v = TX_Valid;
        end
        chk("guard two bytes", 32'(np), 2);
        chk("guard spacing", 32'(t_rise[1] - t_rise[0]), 6);
        wait_idle("guard", 100);
        chk("guard rx_n", 32'(rx_n), 2);
        chk("guard rx_d1", 32'(rx_d[1]), 32'hA2);
        never_fall = 1'b0;

        // Asynchronous reset while waiting for the UART to finish
        do_reset();
        frame_len = 20;
        push(1, 8'h99, 1'b1);
        for (k = 0; k < 50; k++) begin
            tick();
            if (Grant == 4'b0010 && !TX_Ready && !TX_Valid) break;
        end
        chk("areset reached wait_done", 32'(k < 50), 1);
        chk("areset pre data", 32'(TX_DataIn), 32'h99);
        Rst = 1'b1;
        #1;
        chk("areset grant", 32'(Grant), 0);
        chk("areset tx_valid", 32'(TX_Valid), 0);
        chk("areset tx_data", 32'(TX_DataIn), 0);
        chk("areset busy", 32'(Busy), 0);
        chk("areset ready", 32'(Req_Ready), 0);
        chk("areset timeout", 32'(Timeout_Err), 0);
        do_reset();
        push(0, 8'h5A, 1'b1);
        push(2, 8'h5C, 1'b1);
        wait_idle("areset", 200);
        chk("areset rx_n", 32'(rx_n), 2);
        chk("areset rx_d0", 32'(rx_d[0]), 32'h5A);
        chk("areset rx_g0", 32'(rx_g[0]), 32'b0001);

        chk("invariants", 32'(inv_err), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit handshake (TX_Valid/TX_Ready/TX_DataIn) between N_REQ byte-stream requesters.
- Arbitration is round-robin, at packet granularity: a granted requester keeps the transmitter until it sends a byte flagged Last, or until it stalls longer than LOCK_TIMEOUT.
- Sits between the command/debug sources and the UART, and sequences each byte through the UART's registered start / end-of-transmission behaviour.

Parameters:
N_REQ, 4, number of requesters (2..8)
LOCK_TIMEOUT, 16, idle cycles in LOAD before a stalled owner loses its grant (>=2)
START_GUARD, 3, maximum cycles to wait for TX_Ready to fall after issue

Ports:
Clk  input  1  system clock
Rst  input  1  reset
Req_Valid  input  N_REQ  per-requester byte valid
Req_Data  input  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i]
Req_Last  input  N_REQ  byte is last of packet
Req_Ready  output  N_REQ  byte accepted (combinational)
Grant  output  N_REQ  one-hot current owner, 0 when idle
TX_Valid  output  1  to UART TX_Valid
TX_DataIn  output  8  to UART TX_DataIn, registered
TX_Ready  input  1  from UART TX_Ready (high = transmitter idle)
Busy  output  1  state != IDLE
Timeout_Err  output  N_REQ  one-cycle pulse on the requester whose grant was revoked

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: state IDLE, Grant=0, TX_Valid=0, TX_DataIn=8'h00, Timeout_Err=0, priority pointer=0, counters=0. Req_Ready=0 and Busy=0 follow from state.
- Reset mid-byte takes effect immediately. The UART is reset by the same system; no drain is attempted.
- IDLE:
  - Search Req_Valid starting at the pointer, wrapping mod N_REQ.
  - First hit i: Grant<=onehot(i), go to LOAD.
  - No hit: stay in IDLE.
  - Grant therefore rises 1 cycle after Req_Valid.
- LOAD:
  - Req_Ready[owner]=1; all other Req_Ready bits are 0.
  - If Req_Valid[owner]: TX_DataIn<=byte, last_q<=Req_Last[owner], TX_Valid<=1, lock counter<=0, go to ISSUE.
  - Else, lock counter++. When it reaches LOCK_TIMEOUT-1: Timeout_Err[owner] pulses, Grant<=0, pointer<=owner+1 mod N_REQ, go to IDLE.
  - A partially sent packet is then abandoned.
- ISSUE:
  - Hold TX_Valid=1 and TX_DataIn stable.
  - When TX_Ready=1: TX_Valid<=0, guard counter<=0, go to WAIT_START.
  - TX_Valid is therefore high for exactly one cycle when the UART is idle.
- WAIT_START:
  - TX_DataIn stays held; the UART latches it one cycle after acceptance.
  - If TX_Ready=0: go to WAIT_DONE.
  - Else guard++; when guard reaches START_GUARD, go to WAIT_DONE anyway.
- WAIT_DONE:
  - Wait for TX_Ready=1.
  - If last_q: Grant<=0, pointer<=owner+1 mod N_REQ, go to IDLE.
  - Else: go to LOAD.
- Changes to Req_Valid or Req_Data outside LOAD are ignored. Requesters hold the byte until accepted.
- Simultaneous requests are resolved only in IDLE. New requests during a packet wait; there is no pre-emption.
- Pointer wrap-around: owner N_REQ-1 moves the pointer to 0.
- Minimum byte-to-byte turnaround inside a packet: LOAD→ISSUE→WAIT_START→WAIT_DONE→LOAD, plus the UART frame time.
- Grant and Req_Ready are never multi-hot. TX_Valid is never asserted outside ISSUE.

Test Plan:
- Single request: Req_Valid[2]=1, Data 8'hA5, Last=1 →
  - Grant=4'b0100 next cycle; Req_Ready[2] pulses 1 cycle.
  - TX_Valid high 1 cycle with TX_DataIn=A5.
  - Grant returns to 0 once TX_Ready rises again; pointer=3.
- Contention: all four requesters send 1-byte packets from reset → grants in order 0,1,2,3. Re-assert all → order 0,1,2,3 again, with the wrap from 3 to 0 checked.
- Packet lock: req1 sends 3 bytes (11,22,33, Last on 33) while req0 is pending → UART receives 11,22,33 contiguously, then req0 is granted.
- Stall timeout: req3 sends byte 7E (Last=0), then drops Req_Valid →
  - 16 cycles in LOAD, then Timeout_Err[3] pulses once.
  - Grant=0; the next grant searches from 0.
- Guard: TX_Ready model never falls after accept → WAIT_START exits after 3 cycles, next byte proceeds, no hang.
- Async reset asserted in WAIT_DONE with Grant=0010 → all outputs reach reset values without waiting for a Clk edge; after release, the first request from 0 is served normally.
